// File: rtl/register_file_param.sv
// register_file_param
//   Parametrised N-read / 1-write register file for the decode stage.
//   - Combinational reads with write-through bypass from the single write port.
//   - Optional hard-wired zero register (ZERO_REG=1): register 0 reads 0, and
//     writes or reserves aimed at it are dropped.
//   - One pending-write (busy) bit per register. Decode sets it at issue via
//     rsv_en/rsv_reg, writeback clears it via write_reg/dst_reg, and flush clears
//     all of them. Hazard logic stalls on src_busy.
//
// Strobe protocol: write_reg, rsv_en and flush are single-cycle strobes with
// no handshake. Each is consumed on the rising edge where it is high, and the
// register file never back-pressures. There is no ready signal.
module register_file_param #(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] src_reg,
  output logic [NUM_RD*DW-1:0] src_data,
  output logic [NUM_RD-1:0]    src_busy,
  input  logic                 write_reg,
  input  logic [AW-1:0]        dst_reg,
  input  logic [DW-1:0]        dst_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_reg,
  input  logic                 flush,
  output logic [AW:0]          busy_cnt
);

  localparam int DEPTH    = 1 << AW;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // A write or reserve aimed at the hard-wired zero register is dropped entirely.
  logic wr_ok;
  logic rsv_ok;
  assign wr_ok  = write_reg & ~(HAS_ZERO & (dst_reg == '0));
  assign rsv_ok = rsv_en & ~(HAS_ZERO & (rsv_reg == '0));

  // Data storage: clear everything on reset, otherwise store the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[dst_reg] <= dst_data;
    end
  end

  // Next busy vector. Flush wins over everything. The reserve is applied after
  // the writeback clear, so a same-cycle reserve of the same register (a newer
  // producer) leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_ok) begin
        busy_nxt[dst_reg] = 1'b0;
      end
      if (rsv_ok) begin
        busy_nxt[rsv_reg] = 1'b1;
      end
    end
    if (HAS_ZERO) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Population count of the next busy vector. It is AW+1 bits wide so that
  // the all-busy case (2**AW) fits without wrapping.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  // Scoreboard state and its registered count move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports are independent copies of the same priority mux:
  // zero register, then bypass from the write port, then storage.
  // A writeback to the addressed register clears its stall in the same cycle.
  // A reserve made this cycle shows up only next cycle, because it goes
  // through busy.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zero_hit;
    logic          byp_hit;
    logic [DW-1:0] rd_data;

    assign addr     = src_reg[i*AW +: AW];
    assign zero_hit = HAS_ZERO & (addr == '0);
    assign byp_hit  = write_reg & (dst_reg == addr);
    assign rd_data  = zero_hit ? '0 : (byp_hit ? dst_data : mem[addr]);

    assign src_data[i*DW +: DW] = rd_data;
    assign src_busy[i]          = ~zero_hit & busy[addr] & ~byp_hit;
  end

endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param
//   Two instances share the write, reserve, flush and reset inputs:
//     u_rf2 : default parameters (2 read ports, no zero register)
//     u_rf4 : 4 read ports, ZERO_REG=1
//   A behavioural model (arrays of data and busy flags per instance) predicts
//   every output. Directed scenarios come first, followed by random traffic.
module tb_register_file_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        write_reg;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data;
  logic        rsv_en;
  logic [3:0]  rsv_reg;
  logic        flush;

  logic [7:0]  src_reg_a;
  logic [31:0] src_data_a;
  logic [1:0]  src_busy_a;
  logic [4:0]  busy_cnt_a;

  logic [15:0] src_reg_b;
  logic [63:0] src_data_b;
  logic [3:0]  src_busy_b;
  logic [4:0]  busy_cnt_b;

  register_file_param #(.DW(16), .AW(4), .NUM_RD(2), .ZERO_REG(0)) u_rf2 (
    .clk(clk), .rst(rst),
    .src_reg(src_reg_a), .src_data(src_data_a), .src_busy(src_busy_a),
    .write_reg(write_reg), .dst_reg(dst_reg), .dst_data(dst_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .flush(flush),
    .busy_cnt(busy_cnt_a)
  );

  register_file_param #(.DW(16), .AW(4), .NUM_RD(4), .ZERO_REG(1)) u_rf4 (
    .clk(clk), .rst(rst),
    .src_reg(src_reg_b), .src_data(src_data_b), .src_busy(src_busy_b),
    .write_reg(write_reg), .dst_reg(dst_reg), .dst_data(dst_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .flush(flush),
    .busy_cnt(busy_cnt_b)
  );

  // ---------------- reference model ----------------
  // Index k: 0 = u_rf2, 1 = u_rf4.
  logic [15:0] m_mem  [2][16];
  bit          m_busy [2][16];
  bit          m_zero [2] = '{1'b0, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int k, input logic [3:0] a);
    if (m_zero[k] && a == 4'd0) return 16'h0;
    if (write_reg && dst_reg == a) return dst_data;
    return m_mem[k][a];
  endfunction

  function automatic logic exp_busy(input int k, input logic [3:0] a);
    if (m_zero[k] && a == 4'd0) return 1'b0;
    return m_busy[k][a] && !(write_reg && dst_reg == a);
  endfunction

  function automatic logic [4:0] exp_cnt(input int k);
    int c = 0;
    for (int r = 0; r < 16; r++) c += int'(m_busy[k][r]);
    return 5'(c);
  endfunction

  // Apply one rising edge's worth of architectural rules to the model.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int r = 0; r < 16; r++) begin
          m_mem[k][r]  = 16'h0;
          m_busy[k][r] = 1'b0;
        end
      end else begin
        bit wr_ok;
        bit rs_ok;
        wr_ok = write_reg && !(m_zero[k] && dst_reg == 4'd0);
        rs_ok = rsv_en && !(m_zero[k] && rsv_reg == 4'd0);
        if (wr_ok) m_mem[k][dst_reg] = dst_data;
        if (flush) begin
          for (int r = 0; r < 16; r++) m_busy[k][r] = 1'b0;
        end else begin
          if (wr_ok) m_busy[k][dst_reg] = 1'b0;
          if (rs_ok) m_busy[k][rsv_reg] = 1'b1;
        end
      end
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic check_outputs();
    for (int p = 0; p < 2; p++) begin
      check_val($sformatf("a_data%0d", p), 32'(src_data_a[p*16 +: 16]),
                32'(exp_data(0, src_reg_a[p*4 +: 4])));
      check_val($sformatf("a_busy%0d", p), 32'(src_busy_a[p]),
                32'(exp_busy(0, src_reg_a[p*4 +: 4])));
    end
    for (int p = 0; p < 4; p++) begin
      check_val($sformatf("b_data%0d", p), 32'(src_data_b[p*16 +: 16]),
                32'(exp_data(1, src_reg_b[p*4 +: 4])));
      check_val($sformatf("b_busy%0d", p), 32'(src_busy_b[p]),
                32'(exp_busy(1, src_reg_b[p*4 +: 4])));
    end
    check_val("a_cnt", 32'(busy_cnt_a), 32'(exp_cnt(0)));
    check_val("b_cnt", 32'(busy_cnt_b), 32'(exp_cnt(1)));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge. Checks run 1 time unit later, and the
  // model advances on the rising edge.
  task automatic step(input bit do_chk);
    #1;
    if (do_chk) check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst       = 1'b0;
    write_reg = 1'b0;
    rsv_en    = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] r, input logic [15:0] d);
    write_reg = 1'b1;
    dst_reg   = r;
    dst_data  = d;
  endtask

  task automatic do_rsv(input logic [3:0] r);
    rsv_en  = 1'b1;
    rsv_reg = r;
  endtask

  task automatic read_all(input logic [3:0] r);
    src_reg_a = {r, r};
    src_reg_b = {r, r, r, r};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    dst_reg = '0; dst_data = '0; rsv_reg = '0;
    src_reg_a = '0; src_reg_b = '0;
    @(negedge clk);

    // Reset, then read every register on every port.
    rst = 1'b1;
    step(1'b0);
    idle();
    for (int r = 0; r < 16; r++) begin
      read_all(4'(r));
      step(1'b1);
    end

    // Write then readback, and same-cycle bypass on port 1.
    do_write(4'd5, 16'hBEEF);
    step(1'b1);
    idle();
    read_all(4'd5);
    #1 check_val("t2_readback", 32'(src_data_a[15:0]), 32'h0000BEEF);
    step(1'b1);
    do_write(4'd7, 16'h1234);
    src_reg_a = {4'd7, 4'd5};
    #1 check_val("t2_bypass", 32'(src_data_a[31:16]), 32'h00001234);
    step(1'b1);
    idle();

    // Reserve r3, then write it back through the bypass.
    do_rsv(4'd3);
    step(1'b1);
    idle();
    read_all(4'd3);
    #1 check_val("t3_busy", 32'(src_busy_a[0]), 32'd1);
    check_val("t3_cnt1", 32'(busy_cnt_a), 32'd1);
    step(1'b1);
    do_write(4'd3, 16'h00AA);
    #1 check_val("t3_wb_busy", 32'(src_busy_a[0]), 32'd0);
    check_val("t3_wb_data", 32'(src_data_a[15:0]), 32'h000000AA);
    step(1'b1);
    idle();
    #1 check_val("t3_cnt0", 32'(busy_cnt_a), 32'd0);
    step(1'b1);

    // A reserve and a write to r9 in the same cycle: the data is stored and
    // r9 stays busy.
    do_write(4'd9, 16'h5A5A);
    do_rsv(4'd9);
    step(1'b1);
    idle();
    read_all(4'd9);
    #1 check_val("t4_r9_busy", 32'(src_busy_a[1]), 32'd1);
    check_val("t4_r9_data", 32'(src_data_a[31:16]), 32'h00005A5A);
    step(1'b1);
    do_rsv(4'd2); step(1'b1);
    do_rsv(4'd4); step(1'b1);
    do_rsv(4'd6); step(1'b1);
    idle();
    #1 check_val("t4_cnt4", 32'(busy_cnt_a), 32'd4);
    flush = 1'b1;
    step(1'b1);
    idle();
    read_all(4'd5);
    #1 check_val("t4_flush_cnt", 32'(busy_cnt_a), 32'd0);
    check_val("t4_retained", 32'(src_data_a[15:0]), 32'h0000BEEF);
    step(1'b1);

    // Register 0 with and without the zero register.
    do_write(4'd0, 16'hFFFF);
    do_rsv(4'd0);
    step(1'b1);
    idle();
    read_all(4'd0);
    #1 check_val("t5_nz_data", 32'(src_data_a[15:0]), 32'h0000FFFF);
    check_val("t5_z_data", 32'(src_data_b[15:0]), 32'h0);
    check_val("t5_z_busy", 32'(src_busy_b[0]), 32'd0);
    check_val("t5_z_cnt", 32'(busy_cnt_b), 32'd0);
    step(1'b1);

    // Reserve every register, then reset together with a write.
    for (int r = 0; r < 16; r++) begin
      do_rsv(4'(r));
      step(1'b1);
    end
    idle();
    #1 check_val("t6_cnt16", 32'(busy_cnt_a), 32'd16);
    check_val("t6_cnt15_z", 32'(busy_cnt_b), 32'd15);
    step(1'b1);
    rst = 1'b1;
    do_write(4'd5, 16'h7777);
    step(1'b0);
    idle();
    read_all(4'd5);
    #1 check_val("t6_rst_cnt", 32'(busy_cnt_a), 32'd0);
    check_val("t6_rst_data", 32'(src_data_a[15:0]), 32'h0);
    step(1'b1);

    // Four ports of the wider instance reading distinct registers.
    for (int r = 1; r <= 4; r++) begin
      do_write(4'(r), 16'(16'h1100 * r + r));
      step(1'b1);
    end
    idle();
    src_reg_b = {4'd4, 4'd3, 4'd2, 4'd1};
    #1 check_val("t6_p3", 32'(src_data_b[63:48]), 32'h00004404);
    check_val("t6_p0", 32'(src_data_b[15:0]), 32'h00001101);
    step(1'b1);

    // Random traffic with biased address collisions.
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      write_reg = 1'($urandom_range(0, 1));
      dst_reg   = 4'($urandom_range(0, 15));
      dst_data  = 16'($urandom);
      rsv_en    = 1'($urandom_range(0, 1));
      rsv_reg   = ($urandom_range(0, 3) == 0) ? dst_reg : 4'($urandom_range(0, 15));
      for (int p = 0; p < 2; p++)
        src_reg_a[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? dst_reg : 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++)
        src_reg_b[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? dst_reg : 4'($urandom_range(0, 15));
      step(1'b1);
    end
    idle();
    step(1'b1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
